// File: rtl/student_serial_adder_if.sv
// Operand/result bundle for student_serial_adder.
// Optional subtract select is present only when SERIAL_ADDER_SUB_EN is defined.
interface student_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             busy;
    logic             done;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (
        output start, a_in, b_in, c_in, sub,
        input  sum_out, carry_out, busy, done
    );
    modport slave (
        input  start, a_in, b_in, c_in, sub,
        output sum_out, carry_out, busy, done
    );
`else
    modport master (
        output start, a_in, b_in, c_in,
        input  sum_out, carry_out, busy, done
    );
    modport slave (
        input  start, a_in, b_in, c_in,
        output sum_out, carry_out, busy, done
    );
`endif
endinterface

// File: rtl/student_serial_adder.sv
// Bit-serial WIDTH-bit adder built around a single full-adder cell.
// Operands are captured on an accepted start and processed LSB-first, one bit per clock;
// the parallel result and final carry appear with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds subtract select, a - b via ~b + 1).
//
// state | meaning
// IDLE  | waiting for start, last result held
// RUN   | shifting one bit pair per clock through the full adder
// DONE  | result valid, done pulse; start here chains the next operation

module student_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module student_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    student_serial_adder_if.slave         bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             carry_q, carry_d;

    logic             accept;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] b_load;
    logic             cy_load;

    assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign last_bit = (cnt_q == LAST);

    // Subtraction is a + ~b + 1, so only the loaded B operand and initial carry differ.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load  = bus.sub ? ~bus.b_in : bus.b_in;
    assign cy_load = bus.sub ? 1'b1      : bus.c_in;
`else
    assign b_load  = bus.b_in;
    assign cy_load = bus.c_in;
`endif

    student_full_adder u_fa (
        .a_i     (a_sr_q[0]),
        .b_i     (b_sr_q[0]),
        .c_i     (cy_q),
        .sum_o   (fa_sum),
        .carry_o (fa_carry)
    );

    // Next-state decode; start is only honoured outside RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, shift one bit per RUN cycle, otherwise hold.
    always_comb begin
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        carry_d = carry_q;
        if (accept) begin
            a_sr_d  = bus.a_in;
            b_sr_d  = b_load;
            cy_d    = cy_load;
            cnt_d   = '0;
            sum_d   = '0;
            carry_d = 1'b0;
        end else if (state_q == RUN) begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            sum_d  = {fa_sum, sum_q[WIDTH-1:1]};
            cy_d   = fa_carry;
            cnt_d  = cnt_q + CW'(1);
            if (last_bit) carry_d = fa_carry;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
        end
    end

    assign bus.sum_out   = sum_q;
    assign bus.carry_out = carry_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_student_serial_adder.sv
// Self-checking bench for student_serial_adder (WIDTH=8): directed vectors plus
// randomized operations against an integer-arithmetic reference.
module tb_student_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    student_serial_adder_if #(.WIDTH(W)) bus ();

    student_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer sum, split into low WIDTH bits and bit WIDTH.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        longint unsigned r;
        if (s) r = longint'(a) + ((longint'(1) << W) - 1 - longint'(b)) + 1;
        else   r = longint'(a) + longint'(b) + longint'(c);
        return r[W:0];
    endfunction

    task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s);
        bus.start = st;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.c_in  = c;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = s;
`else
        if (s) $display("note: subtract requested without SERIAL_ADDER_SUB_EN");
`endif
    endtask

    // Advance edge by edge until done, counting busy cycles; bounded.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && cycles < W + 6) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    // Starts one operation at the next edge, checks latency, busy length and result.
    // Returns positioned in the DONE cycle, 1 time unit after the edge.
    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s);
        int cyc, bc;
        logic [W:0] exp;
        exp = model(a, b, c, s);
        drive(1'b1, a, b, c, s);
        @(posedge clk); #1;
        drive(1'b0, $urandom, $urandom, $urandom, 1'b0);
        wait_done(cyc, bc);
        tests_run++;
        if (cyc !== W) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d edges, expected %0d", nm, cyc, W);
        end
        tests_run++;
        if (bc !== W) begin
            tests_failed++;
            $display("FAIL %s busy_len: got %0d, expected %0d", nm, bc, W);
        end
        tests_run++;
        if ({bus.carry_out, bus.sum_out} !== exp) begin
            tests_failed++;
            $display("FAIL %s result: got c=%b s=%h, expected c=%b s=%h",
                     nm, bus.carry_out, bus.sum_out, exp[W], exp[W-1:0]);
        end
    endtask

    // After a DONE cycle with no new start: done drops, result stays.
    task automatic check_hold(input string nm);
        logic [W:0] held;
        held = {bus.carry_out, bus.sum_out};
        @(posedge clk); #1;
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.carry_out, bus.sum_out} !== held) begin
            tests_failed++;
            $display("FAIL %s hold: got done=%b busy=%b c/s=%h, expected 0 0 %h",
                     nm, bus.done, bus.busy, {bus.carry_out, bus.sum_out}, held);
        end
    endtask

    task automatic test_reset;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.sum_out, bus.carry_out, bus.busy, bus.done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got s=%h c=%b busy=%b done=%b, expected all 0",
                     bus.sum_out, bus.carry_out, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed;
        do_op("zero", 8'h00, 8'h00, 1'b0, 1'b0);
        check_hold("zero");
        do_op("ff_plus_1", 8'hFF, 8'h01, 1'b0, 1'b0);
        check_hold("ff_plus_1");
    endtask

    task automatic test_back_to_back;
        do_op("b2b_first", 8'hA5, 8'h5A, 1'b1, 1'b0);
        do_op("b2b_second", 8'h3C, 8'h0F, 1'b0, 1'b0);
        check_hold("b2b_second");
    endtask

    task automatic test_start_while_busy;
        int cyc, bc;
        drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_done(cyc, bc);
        tests_run++;
        if (cyc !== W - 3) begin
            tests_failed++;
            $display("FAIL busy_start latency: got %0d more edges, expected %0d", cyc, W - 3);
        end
        tests_run++;
        if ({bus.carry_out, bus.sum_out} !== 9'h046) begin
            tests_failed++;
            $display("FAIL busy_start result: got c=%b s=%h, expected c=0 s=46",
                     bus.carry_out, bus.sum_out);
        end
        check_hold("busy_start");
    endtask

    task automatic test_reset_mid_run;
        int seen_done;
        drive(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.sum_out, bus.carry_out, bus.busy, bus.done} !== '0) begin
            tests_failed++;
            $display("FAIL midrun_reset: got s=%h c=%b busy=%b done=%b, expected all 0",
                     bus.sum_out, bus.carry_out, bus.busy, bus.done);
        end
        seen_done = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done++;
        end
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
        end
        tests_run++;
        if (seen_done !== 0) begin
            tests_failed++;
            $display("FAIL midrun_abort: got %0d done/busy cycles after reset, expected 0", seen_done);
        end
        do_op("after_reset", 8'h01, 8'h02, 1'b0, 1'b0);
        check_hold("after_reset");
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        do_op("sub_neg", 8'h05, 8'h07, 1'b1, 1'b1);
        do_op("sub_pos", 8'h07, 8'h05, 1'b0, 1'b1);
        check_hold("sub_pos");
        tests_run++;
        if ({bus.carry_out, bus.sum_out} !== 9'h102) begin
            tests_failed++;
            $display("FAIL sub_const: got c=%b s=%h, expected c=1 s=02", bus.carry_out, bus.sum_out);
        end
    endtask
`endif

    task automatic test_random;
        logic s;
        for (int i = 0; i < 30; i++) begin
            s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom_range(0, 1));
`endif
            do_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), s);
            if ($urandom_range(0, 1) == 1) check_hold($sformatf("rand%0d", i));
        end
        check_hold("rand_end");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
